fu_exec_complete: RTL

Execution and completion stage behind the reservation station. Accepts up to three issued instructions per cycle (ALU0, ALU1, load/store unit), executes them, and broadcasts results on two writeback buses that feed the reservation-station wakeup and ROB completion. Drives the per-FU free vector that the station samples as its functional-unit table.

---
 rtl/fu_exec_complete.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/fu_exec_complete.sv
// fu_exec_complete
//   Execution/completion stage behind the reservation station. Three issue
//   ports (ALU0, ALU1, LSU) execute and broadcast on two writeback buses.
//   Bus 0 belongs to ALU0 alone. ALU1 and the LSU share bus 1 through a
//   round-robin arbiter.
//
// Ports
//   clk, rst                  clock, async active-high reset
//   iss_valid[2:0]            issue strobe per FU (0 ALU0, 1 ALU1, 2 LSU)
//   iss_*K                    per-port opcode/funct3/alt/rd/rob/a/b/imm
//   fu_free[2:0]              FU can accept an issue this cycle
//   wbN_valid/we/preg/data/rob  writeback broadcast, N = 0,1
//   mem_req/we/addr/wdata/size  LSU memory request
//   mem_ack, mem_rdata        memory handshake pulse and load data
module fu_exec_complete #(
  parameter int PREG_WIDTH = 6,
  parameter int ROB_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            iss_valid,
  input  logic [6:0]            iss_opcode0, iss_opcode1, iss_opcode2,
  input  logic [2:0]            iss_funct30, iss_funct31, iss_funct32,
  input  logic                  iss_alt0, iss_alt1, iss_alt2,
  input  logic [PREG_WIDTH-1:0] iss_rd0, iss_rd1, iss_rd2,
  input  logic [ROB_WIDTH-1:0]  iss_rob0, iss_rob1, iss_rob2,
  input  logic [31:0]           iss_a0, iss_a1, iss_a2,
  input  logic [31:0]           iss_b0, iss_b1, iss_b2,
  input  logic [31:0]           iss_imm0, iss_imm1, iss_imm2,
  output logic [2:0]            fu_free,
  output logic                  wb0_valid, wb0_we,
  output logic [PREG_WIDTH-1:0] wb0_preg,
  output logic [31:0]           wb0_data,
  output logic [ROB_WIDTH-1:0]  wb0_rob,
  output logic                  wb1_valid, wb1_we,
  output logic [PREG_WIDTH-1:0] wb1_preg,
  output logic [31:0]           wb1_data,
  output logic [ROB_WIDTH-1:0]  wb1_rob,
  output logic                  mem_req, mem_we,
  output logic [31:0]           mem_addr, mem_wdata,
  output logic [2:0]            mem_size,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_rdata
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WB} lsu_state_t;

  function automatic logic [31:0] alu(input logic [6:0] op, input logic [2:0] f3,
                                      input logic alt, input logic [31:0] a,
                                      input logic [31:0] b, input logic [31:0] imm);
    logic [31:0] op2;
    logic [31:0] y;
    op2 = (op == OP_R) ? b : imm;
    case (f3)
      3'b000:  y = (op == OP_R && alt) ? a - op2 : a + op2;
      3'b001:  y = a << op2[4:0];
      3'b010:  y = {31'd0, $signed(a) < $signed(op2)};
      3'b011:  y = {31'd0, a < op2};
      3'b100:  y = a ^ op2;
      3'b101:  y = alt ? $unsigned($signed(a) >>> op2[4:0]) : a >> op2[4:0];
      3'b110:  y = a | op2;
      default: y = a & op2;
    endcase
    if (op == OP_LUI)                y = imm;
    else if (op != OP_R && op != OP_I) y = 32'd0;
    return y;
  endfunction

  // ---------------- ALU0 / bus 0 ----------------
  logic                  r_wb0_v;
  logic [PREG_WIDTH-1:0] r_wb0_rd;
  logic [ROB_WIDTH-1:0]  r_wb0_rob;
  logic [31:0]           r_wb0_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb0_v   <= 1'b0;
      r_wb0_rd  <= '0;
      r_wb0_rob <= '0;
      r_wb0_d   <= '0;
    end else begin
      r_wb0_v <= iss_valid[0];
      if (iss_valid[0]) begin
        r_wb0_rd  <= iss_rd0;
        r_wb0_rob <= iss_rob0;
        r_wb0_d   <= alu(iss_opcode0, iss_funct30, iss_alt0, iss_a0, iss_b0, iss_imm0);
      end
    end
  end

  assign wb0_valid = r_wb0_v;
  assign wb0_we    = r_wb0_v;
  assign wb0_preg  = r_wb0_rd;
  assign wb0_rob   = r_wb0_rob;
  assign wb0_data  = r_wb0_d;

  // ---------------- ALU1 pending / LSU state ----------------
  logic                  r_p1_v;
  logic [PREG_WIDTH-1:0] r_p1_rd;
  logic [ROB_WIDTH-1:0]  r_p1_rob;
  logic [31:0]           r_p1_d;

  lsu_state_t            r_state, w_next;
  logic [31:0]           r_l_addr, r_l_wdata, r_l_data;
  logic [2:0]            r_l_size;
  logic                  r_l_we;
  logic [PREG_WIDTH-1:0] r_l_rd;
  logic [ROB_WIDTH-1:0]  r_l_rob;

  logic                  r_last_l;   // 1: LSU was granted last
  logic                  w_pend_l, w_gnt_1, w_gnt_l, w_free1;
  logic [31:0]           w_ld_ext;
  logic                  w_unused;

  assign w_unused = iss_alt2;        // LSU has no use for funct7[5]

  assign w_pend_l = (r_state == S_WB);
  assign w_gnt_1  = r_p1_v  & (~w_pend_l | r_last_l);
  assign w_gnt_l  = w_pend_l & (~r_p1_v  | ~r_last_l);
  // A grant frees the slot in the same cycle so ALU1 can stream one per cycle.
  assign w_free1  = ~r_p1_v | w_gnt_1;

  assign fu_free  = {r_state == S_IDLE, w_free1, 1'b1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p1_v   <= 1'b0;
      r_p1_rd  <= '0;
      r_p1_rob <= '0;
      r_p1_d   <= '0;
      r_last_l <= 1'b1;
    end else begin
      if (w_gnt_1)      r_last_l <= 1'b0;
      else if (w_gnt_l) r_last_l <= 1'b1;
      if (iss_valid[1] && w_free1) begin
        r_p1_v   <= 1'b1;
        r_p1_rd  <= iss_rd1;
        r_p1_rob <= iss_rob1;
        r_p1_d   <= alu(iss_opcode1, iss_funct31, iss_alt1, iss_a1, iss_b1, iss_imm1);
      end else if (w_gnt_1) begin
        r_p1_v <= 1'b0;
      end
    end
  end

  // Load data extension by access size
  always_comb begin
    w_ld_ext = mem_rdata;
    case (r_l_size)
      3'b000:  w_ld_ext = {{24{mem_rdata[7]}},  mem_rdata[7:0]};
      3'b001:  w_ld_ext = {{16{mem_rdata[15]}}, mem_rdata[15:0]};
      3'b100:  w_ld_ext = {24'd0, mem_rdata[7:0]};
      3'b101:  w_ld_ext = {16'd0, mem_rdata[15:0]};
      default: w_ld_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (iss_valid[2]) w_next = S_REQ;
      S_REQ:   if (mem_ack)      w_next = S_WB;
      S_WB:    if (w_gnt_l)      w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_l_addr  <= '0;
      r_l_wdata <= '0;
      r_l_data  <= '0;
      r_l_size  <= '0;
      r_l_we    <= 1'b0;
      r_l_rd    <= '0;
      r_l_rob   <= '0;
    end else begin
      if (r_state == S_IDLE && iss_valid[2]) begin
        r_l_addr  <= iss_a2 + iss_imm2;
        r_l_wdata <= iss_b2;
        r_l_size  <= iss_funct32;
        r_l_we    <= (iss_opcode2 == OP_STORE);
        r_l_rd    <= iss_rd2;
        r_l_rob   <= iss_rob2;
      end
      // Stores broadcast zero data.
      if (r_state == S_REQ && mem_ack)
        r_l_data <= r_l_we ? 32'd0 : w_ld_ext;
    end
  end

  assign mem_req   = (r_state == S_REQ);
  assign mem_we    = mem_req & r_l_we;
  assign mem_addr  = r_l_addr;
  assign mem_wdata = r_l_wdata;
  assign mem_size  = r_l_size;

  // ---------------- bus 1 mux ----------------
  assign wb1_valid = w_gnt_1 | w_gnt_l;
  assign wb1_we    = w_gnt_1 | (w_gnt_l & ~r_l_we);
  assign wb1_preg  = w_gnt_1 ? r_p1_rd  : (w_gnt_l ? r_l_rd   : '0);
  assign wb1_rob   = w_gnt_1 ? r_p1_rob : (w_gnt_l ? r_l_rob  : '0);
  assign wb1_data  = w_gnt_1 ? r_p1_d   : (w_gnt_l ? r_l_data : 32'd0);

endmodule
